// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: round-robin arbiter/sequencer sharing one Booth multiplier core
// among N_REQ requesters, with a watchdog that aborts and resets a hung core.
//
// Ports:
//   clk_i, rst_i             clock (rising edge), asynchronous active-high reset
//   req_valid_i/req_ready_o  per-requester request handshake (ready is a one-hot accept pulse)
//   req_m_i/req_q_i          packed operands, requester i uses slice [i*WIDTH +: WIDTH]
//   rsp_valid_o/rsp_ready_i  per-requester response handshake (valid is one-hot)
//   rsp_product_o, rsp_err_o shared signed product {A,Q} and timeout-abort flag
//   busy_o                   high whenever the sequencer is not idle
//   mul_*                    core interface: start pulse, active-low reset, operand bus,
//                            load/output strobes, result bus and done pulse
module booth_mul_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [N_REQ-1:0]       req_valid_i,
    output logic [N_REQ-1:0]       req_ready_o,
    input  logic [N_REQ*WIDTH-1:0] req_m_i,
    input  logic [N_REQ*WIDTH-1:0] req_q_i,
    output logic [N_REQ-1:0]       rsp_valid_o,
    input  logic [N_REQ-1:0]       rsp_ready_i,
    output logic [2*WIDTH-1:0]     rsp_product_o,
    output logic                   rsp_err_o,
    output logic                   busy_o,
    output logic                   mul_start_o,
    output logic                   mul_rst_n_o,
    output logic [WIDTH-1:0]       mul_din_o,
    input  logic                   mul_ld_m_i,
    input  logic                   mul_ld_q_i,
    input  logic                   mul_out_a_i,
    input  logic                   mul_out_q_i,
    input  logic [WIDTH-1:0]       mul_dout_i,
    input  logic                   mul_stop_i
);

    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {StIdle, StStart, StRun, StAbort, StRespond} state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    gnt_q, gnt_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] qop_q, qop_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] qres_q, qres_d;
    logic             err_q, err_d;
    logic [CW-1:0]    wd_q, wd_d;

    logic             arb_found;
    logic [PW-1:0]    arb_idx;
    logic [PW-1:0]    cand;

    // The operand mux only needs the Q strobe; M is the default value on the bus.
    logic unused_ld_m;
    assign unused_ld_m = mul_ld_m_i;

    // Search upward from ptr+1 with wrap; the last winner is therefore checked last.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = ptr_q;
        cand      = ptr_q;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = PW'((32'(ptr_q) + k) % N_REQ);
            if (!arb_found && req_valid_i[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        gnt_d         = gnt_q;
        m_d           = m_q;
        qop_d         = qop_q;
        a_d           = a_q;
        qres_d        = qres_q;
        err_d         = err_q;
        wd_d          = wd_q;
        req_ready_o   = '0;
        rsp_valid_o   = '0;
        rsp_product_o = '0;
        rsp_err_o     = 1'b0;
        mul_start_o   = 1'b0;
        mul_din_o     = '0;

        unique case (state_q)
            StIdle: begin
                // rst_i gating keeps req_ready low while reset is held.
                if (arb_found && !rst_i) begin
                    req_ready_o[arb_idx] = 1'b1;
                    gnt_d   = arb_idx;
                    ptr_d   = arb_idx;
                    m_d     = req_m_i[arb_idx*WIDTH +: WIDTH];
                    qop_d   = req_q_i[arb_idx*WIDTH +: WIDTH];
                    state_d = StStart;
                end
            end
            StStart: begin
                mul_start_o = 1'b1;
                wd_d        = '0;
                a_d         = '0;
                qres_d      = '0;
                err_d       = 1'b0;
                state_d     = StRun;
            end
            StRun: begin
                mul_din_o = mul_ld_q_i ? qop_q : m_q;
                wd_d      = wd_q + 1'b1;
                if (mul_out_a_i) a_d = mul_dout_i;
                if (mul_out_q_i) qres_d = mul_dout_i;
                // A stop in the same cycle as the timeout takes priority.
                if (mul_stop_i) begin
                    err_d   = 1'b0;
                    state_d = StRespond;
                end else if (wd_d == CW'(TIMEOUT - 1)) begin
                    state_d = StAbort;
                end
            end
            StAbort: begin
                a_d     = '0;
                qres_d  = '0;
                err_d   = 1'b1;
                state_d = StRespond;
            end
            StRespond: begin
                rsp_valid_o[gnt_q] = 1'b1;
                rsp_product_o      = {a_q, qres_q};
                rsp_err_o          = err_q;
                if (rsp_ready_i[gnt_q]) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy_o      = (state_q != StIdle);
    assign mul_rst_n_o = ~rst_i & (state_q != StAbort);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            ptr_q   <= PW'(N_REQ - 1);
            gnt_q   <= '0;
            m_q     <= '0;
            qop_q   <= '0;
            a_q     <= '0;
            qres_q  <= '0;
            err_q   <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            m_q     <= m_d;
            qop_q   <= qop_d;
            a_q     <= a_d;
            qres_q  <= qres_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
        end
    end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
`timescale 1ns/1ps
module tb_booth_mul_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 64;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready_o;
    logic [N*W-1:0] req_m, req_q;
    logic [N-1:0]   rsp_valid_o;
    logic [N-1:0]   rsp_ready = '0;
    logic [2*W-1:0] rsp_product_o;
    logic           rsp_err_o, busy_o, mul_start_o, mul_rst_n_o;
    logic [W-1:0]   mul_din_o;
    logic           mul_ld_m, mul_ld_q, mul_out_a, mul_out_q, mul_stop;
    logic [W-1:0]   mul_dout;

    logic [W-1:0]   om [N];
    logic [W-1:0]   oq [N];
    int             n_cmp = 0;
    int             n_mis = 0;
    int             cyc = 0;
    int             stop_at = 29;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        req_m = '0;
        req_q = '0;
        for (int i = 0; i < N; i++) begin
            req_m[i*W +: W] = om[i];
            req_q[i*W +: W] = oq[i];
        end
    end

    booth_mul_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o),
        .req_m_i(req_m), .req_q_i(req_q),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready),
        .rsp_product_o(rsp_product_o), .rsp_err_o(rsp_err_o), .busy_o(busy_o),
        .mul_start_o(mul_start_o), .mul_rst_n_o(mul_rst_n_o), .mul_din_o(mul_din_o),
        .mul_ld_m_i(mul_ld_m), .mul_ld_q_i(mul_ld_q),
        .mul_out_a_i(mul_out_a), .mul_out_q_i(mul_out_q),
        .mul_dout_i(mul_dout), .mul_stop_i(mul_stop)
    );

    function automatic logic [15:0] mul16(input logic [7:0] a, input logic [7:0] b);
        logic signed [15:0] sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        return sa * sb;
    endfunction

    // Reference model of arbitration: first valid index after the last winner.
    function automatic int rr_pick(input int last, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_req_ready"}, 32'(req_ready_o), 0);
        chk({pfx, "_rsp_valid"}, 32'(rsp_valid_o), 0);
        chk({pfx, "_rsp_product"}, 32'(rsp_product_o), 0);
        chk({pfx, "_rsp_err"}, 32'(rsp_err_o), 0);
        chk({pfx, "_busy"}, 32'(busy_o), 0);
        chk({pfx, "_mul_start"}, 32'(mul_start_o), 0);
        chk({pfx, "_mul_din"}, 32'(mul_din_o), 0);
        chk({pfx, "_mul_rst_n"}, 32'(mul_rst_n_o), 0);
    endtask

    // Core model: fixed strobe schedule relative to mul_start; stop_at == 0 means it hangs.
    initial begin : core_model
        logic       run;
        int         cnt;
        logic [7:0] cm, cq;
        logic [15:0] cp;
        run = 1'b0; cnt = 0; cm = '0; cq = '0; cp = '0;
        {mul_ld_m, mul_ld_q, mul_out_a, mul_out_q, mul_stop} = '0;
        mul_dout = '0;
        forever begin
            @(posedge clk);
            #1;
            {mul_ld_m, mul_ld_q, mul_out_a, mul_out_q, mul_stop} = '0;
            mul_dout = 8'($urandom);
            if (rst || !mul_rst_n_o) begin
                run = 1'b0;
            end else if (mul_start_o) begin
                run = 1'b1;
                cnt = 0;
            end else if (run) begin
                cnt++;
                if (cnt == 1) mul_ld_m = 1'b1;
                if (cnt == 2) mul_ld_q = 1'b1;
                if (stop_at > 0) begin
                    if (cnt == stop_at - 2) begin mul_out_a = 1'b1; mul_dout = cp[15:8]; end
                    if (cnt == stop_at - 1) begin mul_out_q = 1'b1; mul_dout = cp[7:0]; end
                    if (cnt == stop_at) mul_stop = 1'b1;
                    // Stray strobes after done must be ignored by the arbiter.
                    if (cnt == stop_at + 1) begin
                        mul_out_a = 1'b1; mul_out_q = 1'b1; mul_dout = 8'hA5; run = 1'b0;
                    end
                end
                #1;
                if (cnt == 1) cm = mul_din_o;
                if (cnt == 2) begin cq = mul_din_o; cp = mul16(cm, cq); end
            end
        end
    end

    // Entered at posedge+1 in IDLE; returns at posedge+1 of the cycle after the handshake.
    task automatic txn(input logic [N-1:0] vmask, input int g, input logic [15:0] ep,
                       input logic ee, input int lat, input int bp);
        int t, nab, tab, bad_acc;
        bit got;
        logic [N-1:0] oh;
        logic [15:0] p0;
        logic [N-1:0] v0;
        logic e0;
        oh = '0;
        oh[g] = 1'b1;
        req_valid = vmask;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            #2;
            if (req_ready_o != 0) got = 1;
        end
        if (!got) begin chk("accept_wait", 0, 1); return; end
        t = cyc;
        chk("grant", 32'(req_ready_o), 32'(oh));
        @(posedge clk); #1;
        req_valid = vmask & ~oh;
        om[g] = 8'($urandom);
        oq[g] = 8'($urandom);
        #2;
        chk("mul_start", 32'(mul_start_o), 1);
        chk("busy", 32'(busy_o), 1);
        got = 0; nab = 0; tab = -1; bad_acc = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk); #3;
            if (!mul_rst_n_o) begin nab++; tab = cyc; end
            if (req_ready_o != 0) bad_acc++;
            if (rsp_valid_o != 0) got = 1;
        end
        if (!got) begin chk("rsp_wait", 0, 1); return; end
        chk("rsp_latency", 32'(cyc - t), 32'(lat));
        chk("rsp_valid", 32'(rsp_valid_o), 32'(oh));
        chk("rsp_product", 32'(rsp_product_o), 32'(ep));
        chk("rsp_err", 32'(rsp_err_o), 32'(ee));
        chk("abort_pulses", 32'(nab), ee ? 1 : 0);
        chk("accept_while_busy", 32'(bad_acc), 0);
        if (ee) chk("abort_cycle", 32'(tab - t), TO + 1);
        p0 = rsp_product_o; v0 = rsp_valid_o; e0 = rsp_err_o;
        for (int i = 0; i < bp; i++) begin
            rsp_ready = ~oh;
            @(posedge clk); #3;
            chk("bp_valid", 32'(rsp_valid_o), 32'(v0));
            chk("bp_product", 32'(rsp_product_o), 32'(p0));
            chk("bp_err", 32'(rsp_err_o), 32'(e0));
            chk("bp_no_accept", 32'(req_ready_o), 0);
        end
        rsp_ready = oh;
        @(posedge clk); #1;
        rsp_ready = '0;
    endtask

    typedef struct {
        int         r;
        logic [7:0] m;
        logic [7:0] q;
        logic [15:0] prod;
        int         bp;
    } vec_t;

    initial begin : main
        vec_t vecs [6];
        int last, g, mode, nrsp;
        logic [N-1:0] vm;
        logic [15:0] ep;

        #500000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1);
    end

    initial begin : stim
        vec_t vecs [6];
        int last, g, mode, nrsp;
        logic [N-1:0] vm, oh;
        logic [15:0] ep;

        vecs[0] = '{1, 8'd7,    8'hFD, 16'hFFEB, 0};
        vecs[1] = '{2, 8'h80,   8'h80, 16'h4000, 5};
        vecs[2] = '{0, 8'h7F,   8'h7F, 16'h3F01, 0};
        vecs[3] = '{3, 8'h80,   8'h7F, 16'hC080, 2};
        vecs[4] = '{0, 8'h00,   8'h55, 16'h0000, 0};
        vecs[5] = '{3, 8'hFF,   8'hFF, 16'h0001, 1};
        for (int i = 0; i < N; i++) begin om[i] = '0; oq[i] = '0; end

        repeat (3) @(posedge clk);
        #3;
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        last = N - 1;

        // Round-robin from reset: all continuously valid, grants 0,1,2,3,0...
        for (int i = 0; i < N; i++) begin om[i] = 8'($urandom); oq[i] = 8'($urandom); end
        for (int i = 0; i < N + 2; i++) begin
            g = rr_pick(last, '1);
            txn('1, g, mul16(om[g], oq[g]), 1'b0, 31, 0);
            last = g;
        end

        // Directed vectors from the table.
        foreach (vecs[i]) begin
            om[vecs[i].r] = vecs[i].m;
            oq[vecs[i].r] = vecs[i].q;
            vm = '0;
            vm[vecs[i].r] = 1'b1;
            txn(vm, vecs[i].r, vecs[i].prod, 1'b0, 31, vecs[i].bp);
            last = vecs[i].r;
        end

        // Hung core: abort, error response, then a normal transaction.
        stop_at = 0;
        om[2] = 8'd9; oq[2] = 8'd9;
        txn(4'b0100, 2, 16'h0000, 1'b1, TO + 2, 2);
        last = 2;
        stop_at = 29;
        om[1] = 8'd5; oq[1] = 8'hF6;
        txn(4'b0110, 1, 16'hFFCE, 1'b0, 31, 0);
        last = 1;

        // Stop lands on the last watchdog cycle: stop wins.
        stop_at = TO - 1;
        om[3] = 8'd12; oq[3] = 8'd11;
        txn(4'b1000, 3, 16'd132, 1'b0, TO + 1, 0);
        last = 3;

        // Randomised transactions against the model.
        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < N; i++) begin om[i] = 8'($urandom); oq[i] = 8'($urandom); end
            vm = N'($urandom_range(1, (1 << N) - 1));
            g = rr_pick(last, vm);
            mode = $urandom_range(0, 5);
            if (mode == 0) begin
                stop_at = 0;
                txn(vm, g, 16'h0000, 1'b1, TO + 2, $urandom_range(0, 3));
            end else if (mode == 1) begin
                stop_at = TO - 1;
                txn(vm, g, mul16(om[g], oq[g]), 1'b0, TO + 1, $urandom_range(0, 3));
            end else begin
                stop_at = 29;
                txn(vm, g, mul16(om[g], oq[g]), 1'b0, 31, $urandom_range(0, 3));
            end
            last = g;
        end
        req_valid = '0;
        stop_at = 29;

        // Reset in the middle of a run.
        @(posedge clk); #1;
        om[2] = 8'd3; oq[2] = 8'd4;
        req_valid = 4'b0100;
        #2;
        oh = 4'b0100;
        chk("rst_seq_grant", 32'(req_ready_o), 32'(oh));
        @(posedge clk); #1;
        req_valid = '0;
        #2;
        chk("rst_seq_start", 32'(mul_start_o), 1);
        repeat (15) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrun");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        nrsp = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #3;
            if (rsp_valid_o != 0 || busy_o) nrsp++;
        end
        chk("no_rsp_after_reset", 32'(nrsp), 0);
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin om[i] = 8'($urandom); oq[i] = 8'($urandom); end
        last = N - 1;
        g = rr_pick(last, '1);
        txn('1, g, mul16(om[g], oq[g]), 1'b0, 31, 0);
        req_valid = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
